// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the system-ID boot checker: FSM state
// encoding and the two word addresses of the sysid slave.
package sysid_check_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID_REQ,
      RD_ID_WAIT,
      RD_TS_REQ,
      RD_TS_WAIT,
      DONE
   } check_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   function automatic logic is_req(input check_state_t s);
      return (s == RD_ID_REQ) || (s == RD_TS_REQ);
   endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the
// system-ID slave.
interface sysid_boot_checker_if;

   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );

endinterface

// File: rtl/sysid_wait_timer.sv
// Per-read wait counter: cleared when a read request starts, counts busy
// cycles, and flags expiry on the last allowed cycle without data.
module sysid_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && !expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Count k means this is the (k+1)-th cycle of the read; the last one allowed is TIMEOUT_CYCLES.
   assign expired = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads sysid words 0 and 1, compares them to
// build-time constants. Optional read timeout enabled by SYSID_TIMEOUT_EN.
module sysid_boot_checker
   import sysid_check_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1490473961,
   parameter bit          AUTO_START     = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   sysid_boot_checker_if.master avm,
   output logic                 busy,
   output logic                 done,
   output logic                 id_ok,
   output logic                 ts_ok,
   output logic                 timeout,
   output logic [31:0]          id_value,
   output logic [31:0]          ts_value
);

   check_state_t state_reg, state_next;
   logic         auto_reg;
   logic         done_reg, done_next;
   logic         id_ok_reg, id_ok_next;
   logic         ts_ok_reg, ts_ok_next;
   logic         timeout_reg, timeout_next;
   logic [31:0]  id_value_reg, id_value_next;
   logic [31:0]  ts_value_reg, ts_value_next;
   logic         word_arrived;
   logic         expired;

   // In a REQ state data only counts when it coincides with acceptance (zero-latency slave).
   assign word_arrived = avm.avm_readdatavalid && (is_req(state_reg) ? !avm.avm_waitrequest : 1'b1);

   always_comb begin
      state_next    = state_reg;
      done_next     = done_reg;
      id_ok_next    = id_ok_reg;
      ts_ok_next    = ts_ok_reg;
      timeout_next  = timeout_reg;
      id_value_next = id_value_reg;
      ts_value_next = ts_value_reg;
      case (state_reg)
         IDLE: begin
            if (start || auto_reg) begin
               state_next = RD_ID_REQ;
            end
         end
         RD_ID_REQ, RD_ID_WAIT: begin
            if (word_arrived) begin
               id_value_next = avm.avm_readdata;
               state_next    = RD_TS_REQ;
            end else if (expired) begin
               state_next   = DONE;
               done_next    = 1'b1;
               timeout_next = 1'b1;
               id_ok_next   = 1'b0;
               ts_ok_next   = 1'b0;
            end else if ((state_reg == RD_ID_REQ) && !avm.avm_waitrequest) begin
               state_next = RD_ID_WAIT;
            end
         end
         RD_TS_REQ, RD_TS_WAIT: begin
            if (word_arrived) begin
               ts_value_next = avm.avm_readdata;
               state_next    = DONE;
               done_next     = 1'b1;
               id_ok_next    = (id_value_reg == EXPECTED_ID);
               ts_ok_next    = (avm.avm_readdata == EXPECTED_TS);
            end else if (expired) begin
               state_next   = DONE;
               done_next    = 1'b1;
               timeout_next = 1'b1;
               id_ok_next   = 1'b0;
               ts_ok_next   = 1'b0;
            end else if ((state_reg == RD_TS_REQ) && !avm.avm_waitrequest) begin
               state_next = RD_TS_WAIT;
            end
         end
         DONE: begin
            // Captured words survive a rerun until the new reads overwrite them.
            if (start) begin
               state_next   = RD_ID_REQ;
               done_next    = 1'b0;
               id_ok_next   = 1'b0;
               ts_ok_next   = 1'b0;
               timeout_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         auto_reg     <= AUTO_START;
         done_reg     <= 1'b0;
         id_ok_reg    <= 1'b0;
         ts_ok_reg    <= 1'b0;
         timeout_reg  <= 1'b0;
         id_value_reg <= '0;
         ts_value_reg <= '0;
      end else begin
         state_reg    <= state_next;
         auto_reg     <= 1'b0;
         done_reg     <= done_next;
         id_ok_reg    <= id_ok_next;
         ts_ok_reg    <= ts_ok_next;
         timeout_reg  <= timeout_next;
         id_value_reg <= id_value_next;
         ts_value_reg <= ts_value_next;
      end
   end

`ifdef SYSID_TIMEOUT_EN
   logic timer_clear;

   assign timer_clear = ((state_next == RD_ID_REQ) && (state_reg != RD_ID_REQ)) ||
                        ((state_next == RD_TS_REQ) && (state_reg != RD_TS_REQ));

   sysid_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .enable  (busy),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   assign busy            = (state_reg != IDLE) && (state_reg != DONE);
   assign avm.avm_read    = is_req(state_reg);
   assign avm.avm_address = (state_reg == RD_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
   assign done            = done_reg;
   assign id_ok           = id_ok_reg;
   assign ts_ok           = ts_ok_reg;
   assign timeout         = timeout_reg;
   assign id_value        = id_value_reg;
   assign ts_value        = ts_value_reg;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: directed literal cases followed by random
// slave timing, spurious data and resets, checked against a flag-level model.
`timescale 1ns/1ps
module tb_sysid_boot_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1490473961;
   localparam int          TMO    = 8;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 1'b0;

   sysid_boot_checker_if avm();

   sysid_boot_checker #(
      .EXPECTED_ID    (EXP_ID),
      .EXPECTED_TS    (EXP_TS),
      .AUTO_START     (1'b1),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .avm      (avm),
      .busy     (busy),
      .done     (done),
      .id_ok    (id_ok),
      .ts_ok    (ts_ok),
      .timeout  (timeout),
      .id_value (id_value),
      .ts_value (ts_value)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // ---------------- slave model ----------------
   bit          rand_mode = 1'b0;
   bit          drop_all  = 1'b0;
   int          lat_cfg   = 1;
   int          id_stall_left = 0;
   logic [31:0] word0 = EXP_ID;
   logic [31:0] word1 = EXP_TS;
   bit          pend = 1'b0;
   bit          pend_drop = 1'b0;
   logic        pend_addr = 1'b0;
   int          pend_cnt = 0;

   initial begin
      bit   ret;
      logic ret_addr;
      int   lat;
      avm.avm_waitrequest   = 1'b0;
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata      = '0;
      forever begin
         @(posedge clock);
         #2;
         avm.avm_readdatavalid = 1'b0;
         avm.avm_readdata      = $urandom;
         avm.avm_waitrequest   = 1'b0;
         ret      = 1'b0;
         ret_addr = 1'b0;
         if (!reset_n) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  pend     = 1'b0;
                  ret      = !pend_drop;
                  ret_addr = pend_addr;
               end
            end else if (avm.avm_read) begin
               if (rand_mode) begin
                  avm.avm_waitrequest = ($urandom_range(0, 3) == 0);
               end else if (!avm.avm_address && id_stall_left > 0) begin
                  avm.avm_waitrequest = 1'b1;
                  id_stall_left--;
               end
               if (!avm.avm_waitrequest) begin
                  lat       = rand_mode ? int'($urandom_range(0, 3)) : lat_cfg;
                  pend_drop = drop_all || (rand_mode && $urandom_range(0, 31) == 0);
                  pend_addr = avm.avm_address;
                  if (lat == 0) begin
                     ret      = !pend_drop;
                     ret_addr = pend_addr;
                  end else begin
                     pend     = 1'b1;
                     pend_cnt = lat;
                  end
               end
            end else if (rand_mode) begin
               // stray data with nothing outstanding
               avm.avm_waitrequest = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 7) == 0) avm.avm_readdatavalid = 1'b1;
            end
            if (ret) begin
               avm.avm_readdatavalid = 1'b1;
               avm.avm_readdata      = ret_addr ? word1 : word0;
            end
         end
      end
   end

   // ---------------- behavioural model ----------------
   bit          m_active = 0, m_issued = 0, m_idx = 0, m_done = 0;
   bit          m_id_ok = 0, m_ts_ok = 0, m_tmo = 0, m_first = 0;
   logic [31:0] m_id = '0, m_ts = '0;
   int          m_wait = 0;

   always @(posedge clock) begin
      bit got;
      got = 1'b0;
      if (!reset_n) begin
         m_active = 0; m_issued = 0; m_idx = 0; m_done = 0;
         m_id_ok = 0; m_ts_ok = 0; m_tmo = 0; m_wait = 0;
         m_id = '0; m_ts = '0; m_first = 1;
      end else begin
         if (!m_active) begin
            if (start || m_first) begin
               m_active = 1; m_idx = 0; m_issued = 0; m_wait = 0;
               m_done = 0; m_id_ok = 0; m_ts_ok = 0; m_tmo = 0;
            end
         end else begin
            if (!m_issued) begin
               if (!avm.avm_waitrequest) begin
                  m_issued = 1;
                  got = avm.avm_readdatavalid;
               end
            end else begin
               got = avm.avm_readdatavalid;
            end
            if (got) begin
               if (!m_idx) begin
                  m_id = avm.avm_readdata; m_idx = 1; m_issued = 0; m_wait = 0;
               end else begin
                  m_ts = avm.avm_readdata; m_active = 0; m_done = 1;
                  m_id_ok = (m_id == EXP_ID);
                  m_ts_ok = (m_ts == EXP_TS);
               end
            end
`ifdef SYSID_TIMEOUT_EN
            else if (m_wait == TMO - 1) begin
               m_active = 0; m_done = 1; m_tmo = 1; m_id_ok = 0; m_ts_ok = 0;
            end else begin
               m_wait++;
            end
`endif
         end
         m_first = 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit prev_done = 0;
   int n_runs = 0;
   always @(negedge clock) begin
      if (cmp_on) begin
         chk("busy",     busy,            m_active);
         chk("avm_read", avm.avm_read,    m_active && !m_issued);
         chk("avm_addr", avm.avm_address, m_active && !m_issued && m_idx);
         chk("done",     done,            m_done);
         chk("id_ok",    id_ok,           m_id_ok);
         chk("ts_ok",    ts_ok,           m_ts_ok);
         chk("timeout",  timeout,         m_tmo);
         chk("id_value", id_value,        m_id);
         chk("ts_value", ts_value,        m_ts);
         if (m_done && !prev_done) begin
            n_runs++;
            $display("check %0d: id=%08h ts=%08h id_ok=%0b ts_ok=%0b timeout=%0b",
                     n_runs, id_value, ts_value, id_ok, ts_ok, timeout);
         end
      end
      prev_done = m_done;
   end

   // Caller has just raised start (or released reset) in cycle 0.
   task automatic expect_done_at(input int cyc, input string tag);
      step();
      start = 1'b0;
      for (int i = 1; i < cyc; i++) begin
         chk({tag, "_early"}, done, 1'b0);
         step();
      end
      chk({tag, "_done"}, done, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got no end, expected end");
      $fatal(1, "watchdog");
   end

   initial begin
      bit reached;
      // reset, then test 1: auto start, zero-stall slave with one-cycle data latency
      reset_n = 1'b0;
      step();
      cmp_on = 1'b1;
      step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_read", avm.avm_read, 1'b0);
      reset_n = 1'b1;
      expect_done_at(5, "t1");
      chk("t1_id_ok", id_ok, 1'b1);
      chk("t1_ts_ok", ts_ok, 1'b1);
      chk("t1_id_value", id_value, 32'd0);
      chk("t1_ts_value", ts_value, 32'd1490473961);

      // test 2: wrong timestamp
      word1 = 32'd1490473960;
      start = 1'b1;
      expect_done_at(5, "t2");
      chk("t2_id_ok", id_ok, 1'b1);
      chk("t2_ts_ok", ts_ok, 1'b0);
      chk("t2_ts_value", ts_value, 32'd1490473960);

      // test 3: ID read stalled three cycles
      word1 = EXP_TS;
      id_stall_left = 3;
      start = 1'b1;
      expect_done_at(8, "t3");
      chk("t3_id_ok", id_ok, 1'b1);
      chk("t3_ts_ok", ts_ok, 1'b1);

      // test 4: start while busy is ignored, start after done reruns
      start = 1'b1; step();
      start = 1'b0; step();
      start = 1'b1; step();
      start = 1'b0; step();
      chk("t4_early", done, 1'b0);
      step();
      chk("t4_done", done, 1'b1);
      start = 1'b1;
      expect_done_at(5, "t4b");
      chk("t4b_ts_ok", ts_ok, 1'b1);

`ifdef SYSID_TIMEOUT_EN
      // test 5: data never returned
      drop_all = 1'b1;
      start = 1'b1;
      expect_done_at(TMO + 1, "t5");
      chk("t5_timeout", timeout, 1'b1);
      chk("t5_id_ok", id_ok, 1'b0);
      chk("t5_ts_ok", ts_ok, 1'b0);
      drop_all = 1'b0;
`endif

      // test 6: reset while waiting for the timestamp
      lat_cfg = 3;
      start = 1'b1;
      step();
      start = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         if (m_active && m_idx && m_issued) reached = 1'b1;
         else step();
      end
      chk("t6_reach_ts_wait", reached, 1'b1);
      reset_n = 1'b0;
      step();
      chk("t6_busy", busy, 1'b0);
      chk("t6_read", avm.avm_read, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_id_value", id_value, 32'd0);
      chk("t6_ts_value", ts_value, 32'd0);
      reset_n = 1'b1;
      step();
      chk("t6_relaunch_busy", busy, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         if (done) reached = 1'b1;
         else step();
      end
      chk("t6_relaunch_done", reached, 1'b1);
      chk("t6_relaunch_id_ok", id_ok, 1'b1);

      // random phase
      lat_cfg = 1;
      rand_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         start   = ($urandom_range(0, 9) == 0);
         reset_n = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 39) == 0) begin
            word0 = ($urandom_range(0, 1) == 0) ? EXP_ID : 32'($urandom);
            word1 = ($urandom_range(0, 1) == 0) ? EXP_TS : 32'($urandom);
         end
         step();
      end
      start   = 1'b0;
      reset_n = 1'b1;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
